// File: rtl/matrix_keypad.sv
// 4x4 active-low matrix keypad scanner: rotates a one-cold column drive,
// synchronizes the rows, debounces press and release, and reports a latched key code.
module matrix_keypad #(
  parameter int SCAN_DIV = 1,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key,
  output logic       keypress
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [4:0] NO_KEY = 5'b10000;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     sync_p0, rs;
  logic [3:0]     cap, cap_nx;
  logic [1:0]     cidx, cidx_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [DW-1:0]  div, div_nx;
  logic [3:0]     col_nx;
  logic [4:0]     key_nx;
  logic           keypress_nx;
  logic           idle, match, cnt_done, div_done;

  // Lowest-numbered low row wins when several rows are pulled low together.
  function automatic logic [4:0] key_code(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) r = 2'(i);
    end
    return {1'b0, r, c};
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  assign idle     = (rs == 4'hF);
  assign match    = (rs == cap);
  assign cnt_done = (cnt == CW'(DEBOUNCE - 1));
  assign div_done = (div == DW'(SCAN_DIV - 1));

  // State and datapath registers; sync_p0 -> rs is the row synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0  <= 4'hF;
      rs       <= 4'hF;
      state    <= ST_SCAN;
      cap      <= 4'hF;
      cidx     <= 2'd0;
      cnt      <= '0;
      div      <= '0;
      col      <= 4'b1110;
      key      <= NO_KEY;
      keypress <= 1'b0;
    end else begin
      sync_p0  <= row;
      rs       <= sync_p0;
      state    <= state_nx;
      cap      <= cap_nx;
      cidx     <= cidx_nx;
      cnt      <= cnt_nx;
      div      <= div_nx;
      col      <= col_nx;
      key      <= key_nx;
      keypress <= keypress_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_SCAN:     if (!idle) state_nx = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (!match)        state_nx = ST_SCAN;
        else if (cnt_done) state_nx = ST_PRESSED;
      end
      ST_PRESSED:  if (idle) state_nx = ST_RELEASE;
      ST_RELEASE: begin
        if (!idle)         state_nx = ST_PRESSED;
        else if (cnt_done) state_nx = ST_SCAN;
      end
      default:     state_nx = ST_SCAN;
    endcase
  end

  // Column only advances while scanning or when leaving a capture; it is frozen otherwise.
  always_comb begin
    cap_nx      = cap;
    cidx_nx     = cidx;
    cnt_nx      = cnt;
    div_nx      = div;
    key_nx      = key;
    keypress_nx = keypress;
    case (state)
      ST_SCAN: begin
        if (!idle) begin
          cap_nx = rs;
          cnt_nx = '0;
          div_nx = '0;
        end else if (div_done) begin
          div_nx  = '0;
          cidx_nx = cidx + 2'd1;
        end else begin
          div_nx = div + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!match) begin
          cnt_nx  = '0;
          div_nx  = '0;
          cidx_nx = cidx + 2'd1;
        end else if (cnt_done) begin
          cnt_nx      = '0;
          key_nx      = key_code(cap, cidx);
          keypress_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (idle) cnt_nx = '0;
      end
      ST_RELEASE: begin
        if (!idle) begin
          cnt_nx = '0;
        end else if (cnt_done) begin
          cnt_nx      = '0;
          div_nx      = '0;
          cidx_nx     = cidx + 2'd1;
          key_nx      = NO_KEY;
          keypress_nx = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: ;
    endcase
    col_nx = col_drive(cidx_nx);
  end

endmodule

// File: tb/tb_matrix_keypad.sv
// Bench for matrix_keypad: directed scenarios plus random row activity,
// compared every cycle against a cycle-level behavioural model of the keypad rules.
module tb_matrix_keypad;

  localparam int SCAN_DIV = 1;
  localparam int DEBOUNCE = 3;

  localparam int M_SCAN    = 0;
  localparam int M_DEB     = 1;
  localparam int M_PRESSED = 2;
  localparam int M_RELEASE = 3;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] key;
  logic       keypress;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] rs;
    logic [3:0] cap;
    int         mode;
    int         c;
    int         tick;
    int         run;
    int         key;
    logic       kp;
  } mstate_t;

  mstate_t m;

  matrix_keypad #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key      (key),
    .keypress (keypress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_zero(input logic [3:0] p);
    for (int i = 0; i < 4; i++) begin
      if (p[i] == 1'b0) return i;
    end
    return 0;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t n;
    n.s1 = 4'hF; n.rs = 4'hF; n.cap = 4'hF;
    n.mode = M_SCAN; n.c = 0; n.tick = 0; n.run = 0;
    n.key = 16; n.kp = 1'b0;
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t cur, input logic [3:0] r);
    mstate_t n;
    bit idle, same;
    n = cur;
    n.s1 = r;
    n.rs = cur.s1;
    idle = (cur.rs == 4'hF);
    same = (cur.rs == cur.cap);
    case (cur.mode)
      M_SCAN: begin
        if (!idle) begin
          n.mode = M_DEB; n.cap = cur.rs; n.run = 0; n.tick = 0;
        end else begin
          n.tick = cur.tick + 1;
          if (n.tick >= SCAN_DIV) begin n.tick = 0; n.c = (cur.c + 1) % 4; end
        end
      end
      M_DEB: begin
        if (!same) begin
          n.mode = M_SCAN; n.run = 0; n.tick = 0; n.c = (cur.c + 1) % 4;
        end else begin
          n.run = cur.run + 1;
          if (n.run == DEBOUNCE) begin
            n.mode = M_PRESSED; n.run = 0; n.kp = 1'b1;
            n.key = 4 * lowest_zero(cur.cap) + cur.c;
          end
        end
      end
      M_PRESSED: begin
        if (idle) begin n.mode = M_RELEASE; n.run = 0; end
      end
      M_RELEASE: begin
        if (!idle) begin
          n.mode = M_PRESSED; n.run = 0;
        end else begin
          n.run = cur.run + 1;
          if (n.run == DEBOUNCE) begin
            n.mode = M_SCAN; n.run = 0; n.kp = 1'b0; n.key = 16;
            n.c = (cur.c + 1) % 4; n.tick = 0;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m, row);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("col", col, 4'hF ^ (4'h1 << m.c));
      check_val("col_onecold", $countones(~col), 1);
      check_val("key", key, m.key);
      check_val("keypress", keypress, m.kp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target);
    int k;
    k = 0;
    while (col !== target && k < 8) begin
      step();
      k++;
    end
    check_val("wait_col", col, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    reset = 1'b1;
    row   = 4'hF;
    #1 reset = 1'b0;
    #1 mon_en = 1;

    // Reset hold
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_col", col, 4'b1110);
    check_val("rst_key", key, 16);
    check_val("rst_kp", keypress, 0);
    reset = 1'b1;
    check_val("scan0", col, 4'b1110);
    step(); check_val("scan1", col, 4'b1101);
    step(); check_val("scan2", col, 4'b1011);
    step(); check_val("scan3", col, 4'b0111);
    step(); check_val("scan4", col, 4'b1110);

    // Sub-cycle glitch never lands on a rising edge
    row = 4'b1011;
    #8 row = 4'hF;
    repeat (10) step();
    check_val("glitch_kp", keypress, 0);
    check_val("glitch_key", key, 16);

    // Press detected while column 0 is driven
    wait_col(4'b1011);
    row = 4'b1011;
    repeat (5) step();
    check_val("press_early_kp", keypress, 0);
    step();
    check_val("press_kp", keypress, 1);
    check_val("press_key", key, 8);
    check_val("press_col", col, 4'b1110);
    repeat (3) step();
    check_val("press_frozen", col, 4'b1110);

    row = 4'hF;
    repeat (5) step();
    check_val("rel_early_kp", keypress, 1);
    step();
    check_val("rel_kp", keypress, 0);
    check_val("rel_key", key, 16);
    check_val("rel_col", col, 4'b1101);

    // One-cycle bounce inside the release window restarts the count
    wait_col(4'b1011);
    row = 4'b1011;
    repeat (8) step();
    row = 4'hF;
    repeat (3) step();
    row = 4'b1011;
    step();
    row = 4'hF;
    repeat (5) step();
    check_val("bounce_kp_hold", keypress, 1);
    check_val("bounce_key", key, 8);
    step();
    check_val("bounce_kp_rel", keypress, 0);

    // Two rows low: row 0 wins
    wait_col(4'b1101);
    row = 4'b0110;
    repeat (6) step();
    check_val("multi_kp", keypress, 1);
    check_val("multi_key", key, 3);
    row = 4'hF;
    repeat (8) step();

    // Reset in the middle of a debounce
    wait_col(4'b1011);
    row = 4'b1011;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    check_val("midrst_col", col, 4'b1110);
    check_val("midrst_key", key, 16);
    check_val("midrst_kp", keypress, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    check_val("postrst_kp", keypress, 0);
    row = 4'hF;
    repeat (12) step();

    // Random row activity
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        row = 4'($urandom_range(0, 14));
        #7 row = 4'hF;
        step();
      end else begin
        row = (kind < 5) ? 4'hF : 4'($urandom_range(0, 14));
        repeat ($urandom_range(1, 10)) step();
      end
    end
    row = 4'hF;
    repeat (12) step();

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
